// File: rtl/vga_pkg.sv
// Shared screen, glyph and colour constants for the character window renderer,
// plus the wrap-aware window membership test used for both axes.
package vga_pkg;

    localparam int HDR     = 640;
    localparam int VDR     = 480;
    localparam int GLYPH_W = 8;
    localparam int GLYPH_H = 8;
    localparam int RGB_W   = 9;
    localparam int SCALE_W = 3;
    localparam int X_W     = 10;
    localparam int Y_W     = 9;
    localparam int IDX_W   = 3;

    localparam logic [X_W-1:0]   X_LAST     = 10'(HDR - 1);
    localparam logic [IDX_W-1:0] COL_LAST   = 3'(GLYPH_W - 1);
    localparam logic [IDX_W-1:0] ROW_LAST   = 3'(GLYPH_H - 1);
    localparam logic [RGB_W-1:0] FG_RGB     = 9'h1FF;
    localparam logic [RGB_W-1:0] BG_RGB     = 9'h000;
    localparam logic [RGB_W-1:0] BORDER_RGB = 9'h1C0;

    typedef logic [RGB_W-1:0] rgb_t;

    // Inclusive range test; when lo > hi the window wraps past the screen edge.
    function automatic logic in_window(input logic [X_W-1:0] lo,
                                       input logic [X_W-1:0] hi,
                                       input logic [X_W-1:0] pos);
        logic hit;
        if (lo <= hi) begin
            hit = (pos >= lo) && (pos <= hi);
        end else begin
            hit = (pos >= lo) || (pos <= hi);
        end
        return hit;
    endfunction

endpackage

// File: rtl/char_window_renderer_scale_counter.sv
// scale_counter: sub-count 0..scale followed by a wrapping index 0..IDX_LAST.
// 'idx' is the value that applies to the current pixel/line, so a load-zero
// in the same cycle is already visible on it.
module scale_counter
    import vga_pkg::*;
#(
    parameter int                IDX_W_P  = 3,
    parameter logic [IDX_W_P-1:0] IDX_LAST = 3'd7
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [SCALE_W-1:0] scale,
    input  logic               load_zero,
    input  logic               advance,
    output logic [IDX_W_P-1:0] idx
);

    logic [SCALE_W-1:0] sub_r;
    logic [SCALE_W-1:0] cur_sub_s;
    logic [SCALE_W-1:0] nxt_sub_s;
    logic [IDX_W_P-1:0] idx_r;
    logic [IDX_W_P-1:0] cur_idx_s;
    logic [IDX_W_P-1:0] nxt_idx_s;

    // Effective value for this cycle and the value to hold afterwards.
    always_comb begin
        cur_sub_s = sub_r;
        cur_idx_s = idx_r;
        if (load_zero) begin
            cur_sub_s = {SCALE_W{1'b0}};
            cur_idx_s = {IDX_W_P{1'b0}};
        end else begin
            cur_sub_s = sub_r;
            cur_idx_s = idx_r;
        end
        nxt_sub_s = cur_sub_s;
        nxt_idx_s = cur_idx_s;
        if (advance) begin
            if (cur_sub_s >= scale) begin
                nxt_sub_s = {SCALE_W{1'b0}};
                if (cur_idx_s == IDX_LAST) begin
                    nxt_idx_s = {IDX_W_P{1'b0}};
                end else begin
                    nxt_idx_s = cur_idx_s + {{(IDX_W_P-1){1'b0}}, 1'b1};
                end
            end else begin
                nxt_sub_s = cur_sub_s + {{(SCALE_W-1){1'b0}}, 1'b1};
            end
        end else begin
            nxt_sub_s = cur_sub_s;
        end
    end

    // Counter state; holds through blanking so wrapped windows continue.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sub_r <= {SCALE_W{1'b0}};
            idx_r <= {IDX_W_P{1'b0}};
        end else begin
            sub_r <= nxt_sub_s;
            idx_r <= nxt_idx_s;
        end
    end

    assign idx = cur_idx_s;

endmodule

// File: rtl/char_window_renderer.sv
// char_window_renderer: renders a scaled 8x8 glyph inside a (possibly
// edge-wrapping) window. Stage 0 compares, stage 1 issues the ROM read,
// stage 2 combines the ROM row with the delayed window flag.
// Optional build macro: CWR_BORDER_EN draws the window outline in BORDER_RGB.
module char_window_renderer
    import vga_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               active,
    input  logic [X_W-1:0]     pixelX,
    input  logic [Y_W-1:0]     pixelY,
    input  logic [SCALE_W-1:0] charSize,
    input  logic [X_W-1:0]     posHorStart,
    input  logic [X_W-1:0]     posHorEnd,
    input  logic [Y_W-1:0]     posVerStart,
    input  logic [Y_W-1:0]     posVerEnd,
    input  logic [GLYPH_W-1:0] romData,
    output logic               readEn,
    output logic [IDX_W-1:0]   rowCnt,
    output logic [IDX_W-1:0]   colCnt,
    output logic [RGB_W-1:0]   vgaRGB
);

    logic [SCALE_W-1:0] scale_r;
    logic               h_in_s;
    logic               v_in_s;
    logic               frame_start_s;
    logic               h_load_s;
    logic               h_adv_s;
    logic               v_load_s;
    logic               v_adv_s;
    logic               pix_in_s;
    logic [IDX_W-1:0]   h_idx_s;
    logic [IDX_W-1:0]   v_idx_s;
    logic               win_d2_r;
    logic [IDX_W-1:0]   col_d2_r;

    // Stage 0: window membership and counter controls.
    always_comb begin
        h_in_s        = in_window(posHorStart, posHorEnd, pixelX);
        v_in_s        = in_window({1'b0, posVerStart}, {1'b0, posVerEnd}, {1'b0, pixelY});
        frame_start_s = active && (pixelX == {X_W{1'b0}}) && (pixelY == {Y_W{1'b0}});
        h_adv_s       = active && h_in_s;
        h_load_s      = h_adv_s && (pixelX == posHorStart);
        v_load_s      = active && (pixelX == {X_W{1'b0}}) && (pixelY == posVerStart);
        v_adv_s       = active && (pixelX == X_LAST) && v_in_s;
        pix_in_s      = active && h_in_s && v_in_s;
    end

    // Scale only changes at the first visible pixel of a frame.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            scale_r <= {SCALE_W{1'b0}};
        end else if (frame_start_s) begin
            scale_r <= charSize;
        end else begin
            scale_r <= scale_r;
        end
    end

    scale_counter #(.IDX_W_P(IDX_W), .IDX_LAST(COL_LAST)) u_hcnt (
        .clk       (clk),
        .reset     (reset),
        .scale     (scale_r),
        .load_zero (h_load_s),
        .advance   (h_adv_s),
        .idx       (h_idx_s)
    );

    scale_counter #(.IDX_W_P(IDX_W), .IDX_LAST(ROW_LAST)) u_vcnt (
        .clk       (clk),
        .reset     (reset),
        .scale     (scale_r),
        .load_zero (v_load_s),
        .advance   (v_adv_s),
        .idx       (v_idx_s)
    );

    // Stage 1: ROM read strobe and glyph coordinates.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            readEn <= 1'b0;
            rowCnt <= {IDX_W{1'b0}};
            colCnt <= {IDX_W{1'b0}};
        end else begin
            readEn <= pix_in_s;
            rowCnt <= v_idx_s;
            colCnt <= h_idx_s;
        end
    end

    // Stage 2: window flag and column aligned with the returning ROM row.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            win_d2_r <= 1'b0;
            col_d2_r <= {IDX_W{1'b0}};
        end else begin
            win_d2_r <= readEn;
            col_d2_r <= colCnt;
        end
    end

`ifdef CWR_BORDER_EN
    logic border_s;
    logic border_d1_r;
    logic border_d2_r;

    // Outline pixels: start/end column on a window row, start/end row on a window column.
    always_comb begin
        border_s = active &&
                   ((((pixelX == posHorStart) || (pixelX == posHorEnd)) && v_in_s) ||
                    (((pixelY == posVerStart) || (pixelY == posVerEnd)) && h_in_s));
    end

    // Border flag follows the same two-stage delay as the pixel.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            border_d1_r <= 1'b0;
            border_d2_r <= 1'b0;
        end else begin
            border_d1_r <= border_s;
            border_d2_r <= border_d1_r;
        end
    end

    // Colour select; romData comes straight from the ROM output register.
    always_comb begin
        vgaRGB = {RGB_W{1'b0}};
        if (win_d2_r) begin
            if (border_d2_r) begin
                vgaRGB = BORDER_RGB;
            end else begin
                vgaRGB = romData[COL_LAST - col_d2_r] ? FG_RGB : BG_RGB;
            end
        end else begin
            vgaRGB = {RGB_W{1'b0}};
        end
    end
`else
    // Colour select; romData comes straight from the ROM output register.
    always_comb begin
        vgaRGB = {RGB_W{1'b0}};
        if (win_d2_r) begin
            vgaRGB = romData[COL_LAST - col_d2_r] ? FG_RGB : BG_RGB;
        end else begin
            vgaRGB = {RGB_W{1'b0}};
        end
    end
`endif

endmodule

// File: tb/tb_char_window_renderer.sv
// Directed bench for char_window_renderer. Lines are compressed: each driven
// line visits x=0, the columns of interest and x=639, then a few blank cycles.
module tb_char_window_renderer;

    localparam logic [8:0] FG  = 9'h1FF;
    localparam logic [8:0] BG  = 9'h000;
    localparam logic [8:0] BRD = 9'h1C0;

    logic       clk = 1'b0;
    logic       reset;
    logic       active;
    logic [9:0] pixelX;
    logic [8:0] pixelY;
    logic [2:0] charSize;
    logic [9:0] posHorStart, posHorEnd;
    logic [8:0] posVerStart, posVerEnd;
    logic [7:0] romData;
    logic       readEn;
    logic [2:0] rowCnt, colCnt;
    logic [8:0] vgaRGB;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] rom_mem [8];
    logic [8:0] q_rgb [$];
    logic       q_re  [$];
    logic [2:0] q_row [$];
    logic [2:0] q_col [$];
    int         tag_x [640];
    logic [8:0] exp_a5 [8];

    char_window_renderer dut (
        .clk(clk), .reset(reset), .active(active), .pixelX(pixelX), .pixelY(pixelY),
        .charSize(charSize), .posHorStart(posHorStart), .posHorEnd(posHorEnd),
        .posVerStart(posVerStart), .posVerEnd(posVerEnd), .romData(romData),
        .readEn(readEn), .rowCnt(rowCnt), .colCnt(colCnt), .vgaRGB(vgaRGB)
    );

    always #5 clk = ~clk;

    // Synchronous glyph ROM, one-cycle latency.
    always @(posedge clk) romData <= rom_mem[rowCnt];

    // Output history, one entry per cycle, sampled mid-cycle.
    always @(negedge clk) begin
        q_rgb.push_back(vgaRGB);
        q_re.push_back(readEn);
        q_row.push_back(rowCnt);
        q_col.push_back(colCnt);
    end

    function automatic logic [8:0] glyph(input int row, input int col);
        logic [7:0] d;
        d = rom_mem[row];
        return d[7-col] ? FG : BG;
    endfunction

    task automatic pix(input int x, input int y, input logic act, output int tag);
        @(posedge clk);
        #1;
        active = act;
        pixelX = 10'(x);
        pixelY = 9'(y);
        tag    = q_rgb.size();
    endtask

    task automatic line(input int y, input int a_hi, input int b_lo, input int b_hi);
        int t;
        for (int x = 0; x < 640; x++) tag_x[x] = -1;
        for (int x = 0; x <= a_hi; x++) begin pix(x, y, 1'b1, t); tag_x[x] = t; end
        for (int x = b_lo; x <= b_hi; x++) begin pix(x, y, 1'b1, t); tag_x[x] = t; end
        if (b_hi < 639) begin pix(639, y, 1'b1, t); tag_x[639] = t; end
        for (int k = 0; k < 3; k++) pix(0, y, 1'b0, t);
    endtask

    task automatic frame(input int cs);
        int t;
        charSize = 3'(cs);
        pix(0, 0, 1'b1, t);
        pix(0, 0, 1'b0, t);
    endtask

    task automatic set_win(input int hs, input int he, input int vs, input int ve);
        posHorStart = 10'(hs); posHorEnd = 10'(he);
        posVerStart = 9'(vs);  posVerEnd = 9'(ve);
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        n_tests += 4;
        if (vgaRGB !== 9'h000) begin n_fail++; $display("FAIL reset_rgb got %h exp 000", vgaRGB); end
        if (readEn !== 1'b0)   begin n_fail++; $display("FAIL reset_readEn got %b exp 0", readEn); end
        if (rowCnt !== 3'd0)   begin n_fail++; $display("FAIL reset_rowCnt got %0d exp 0", rowCnt); end
        if (colCnt !== 3'd0)   begin n_fail++; $display("FAIL reset_colCnt got %0d exp 0", colCnt); end
        reset = 1'b0;
    endtask

    task automatic test_s1_glyph();
        int t;
        set_win(316, 323, 236, 243);
        frame(0);
        for (int y = 236; y <= 243; y++) begin
            line(y, 0, 315, 324);
            t = tag_x[316];
            n_tests += 4;
            if (q_row[t+1] !== 3'(y-236)) begin n_fail++; $display("FAIL s1_row y=%0d got %0d exp %0d", y, q_row[t+1], y-236); end
            if (q_re[t+1] !== 1'b1) begin n_fail++; $display("FAIL s1_readEn_in y=%0d got %b exp 1", y, q_re[t+1]); end
            if (q_re[tag_x[315]+1] !== 1'b0) begin n_fail++; $display("FAIL s1_readEn_out y=%0d got %b exp 0", y, q_re[tag_x[315]+1]); end
            if (q_rgb[tag_x[324]+2] !== 9'h000) begin n_fail++; $display("FAIL s1_rgb_out y=%0d got %h exp 000", y, q_rgb[tag_x[324]+2]); end
            for (int k = 0; k < 8; k++) begin
                t = tag_x[316+k];
                n_tests += 2;
                if (q_col[t+1] !== 3'(k)) begin n_fail++; $display("FAIL s1_col y=%0d x=%0d got %0d exp %0d", y, 316+k, q_col[t+1], k); end
                if (y == 236) begin
                    if (q_rgb[t+2] !== exp_a5[k]) begin n_fail++; $display("FAIL s1_rgb_a5 x=%0d got %h exp %h", 316+k, q_rgb[t+2], exp_a5[k]); end
                end else begin
                    if (q_rgb[t+2] !== glyph(y-236, k)) begin n_fail++; $display("FAIL s1_rgb y=%0d x=%0d got %h exp %h", y, 316+k, q_rgb[t+2], glyph(y-236, k)); end
                end
            end
        end
    endtask

    task automatic test_s2_scaling();
        int t;
        set_win(312, 327, 200, 215);
        frame(1);
        for (int y = 200; y <= 203; y++) begin
            line(y, 0, 311, 328);
            for (int k = 0; k < 16; k++) begin
                t = tag_x[312+k];
                n_tests += 3;
                if (q_col[t+1] !== 3'(k/2)) begin n_fail++; $display("FAIL s2_col y=%0d x=%0d got %0d exp %0d", y, 312+k, q_col[t+1], k/2); end
                if (q_row[t+1] !== 3'((y-200)/2)) begin n_fail++; $display("FAIL s2_row y=%0d got %0d exp %0d", y, q_row[t+1], (y-200)/2); end
                if (q_rgb[t+2] !== glyph((y-200)/2, k/2)) begin n_fail++; $display("FAIL s2_rgb y=%0d x=%0d got %h exp %h", y, 312+k, q_rgb[t+2], glyph((y-200)/2, k/2)); end
            end
        end
    endtask

    task automatic test_mid_scale();
        int t;
        set_win(312, 327, 200, 215);
        frame(1);
        charSize = 3'd3;
        line(100, 0, 311, 328);
        line(200, 0, 311, 328);
        for (int k = 0; k < 16; k++) begin
            t = tag_x[312+k];
            n_tests++;
            if (q_col[t+1] !== 3'(k/2)) begin n_fail++; $display("FAIL mid_hold_col x=%0d got %0d exp %0d", 312+k, q_col[t+1], k/2); end
        end
        frame(3);
        line(200, 0, 311, 328);
        for (int k = 0; k < 16; k++) begin
            t = tag_x[312+k];
            n_tests++;
            if (q_col[t+1] !== 3'(k/4)) begin n_fail++; $display("FAIL mid_new_col x=%0d got %0d exp %0d", 312+k, q_col[t+1], k/4); end
        end
    endtask

    task automatic test_hwrap();
        int t;
        set_win(636, 3, 300, 310);
        frame(0);
        line(300, 5, 630, 639);
        line(301, 5, 630, 639);
        for (int k = 0; k < 4; k++) begin
            n_tests += 3;
            t = tag_x[636+k];
            if (q_col[t+1] !== 3'(k)) begin n_fail++; $display("FAIL wrap_right_col x=%0d got %0d exp %0d", 636+k, q_col[t+1], k); end
            t = tag_x[k];
            if (q_col[t+1] !== 3'(4+k)) begin n_fail++; $display("FAIL wrap_left_col x=%0d got %0d exp %0d", k, q_col[t+1], 4+k); end
            if (q_rgb[t+2] !== glyph(1, 4+k)) begin n_fail++; $display("FAIL wrap_left_rgb x=%0d got %h exp %h", k, q_rgb[t+2], glyph(1, 4+k)); end
        end
        t = tag_x[4];
        n_tests += 3;
        if (q_rgb[t+2] !== 9'h000) begin n_fail++; $display("FAIL wrap_x4_rgb got %h exp 000", q_rgb[t+2]); end
        if (q_re[t+1] !== 1'b0) begin n_fail++; $display("FAIL wrap_x4_readEn got %b exp 0", q_re[t+1]); end
        if (q_row[tag_x[0]+1] !== 3'd1) begin n_fail++; $display("FAIL wrap_row got %0d exp 1", q_row[tag_x[0]+1]); end
    endtask

    task automatic test_reset_mid();
        int t;
        set_win(316, 323, 236, 243);
        frame(3);
        pix(0, 236, 1'b1, t);
        for (int x = 316; x <= 319; x++) pix(x, 236, 1'b1, t);
        @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        n_tests += 4;
        if (vgaRGB !== 9'h000) begin n_fail++; $display("FAIL rmid_rgb got %h exp 000", vgaRGB); end
        if (readEn !== 1'b0)   begin n_fail++; $display("FAIL rmid_readEn got %b exp 0", readEn); end
        if (rowCnt !== 3'd0)   begin n_fail++; $display("FAIL rmid_rowCnt got %0d exp 0", rowCnt); end
        if (colCnt !== 3'd0)   begin n_fail++; $display("FAIL rmid_colCnt got %0d exp 0", colCnt); end
        charSize = 3'd5;
        active = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        line(236, 0, 315, 324);
        for (int k = 0; k < 8; k++) begin
            t = tag_x[316+k];
            n_tests += 2;
            if (q_col[t+1] !== 3'(k)) begin n_fail++; $display("FAIL rmid_s1_col x=%0d got %0d exp %0d", 316+k, q_col[t+1], k); end
            if (q_rgb[t+2] !== glyph(0, k)) begin n_fail++; $display("FAIL rmid_s1_rgb x=%0d got %h exp %h", 316+k, q_rgb[t+2], glyph(0, k)); end
        end
    endtask

    task automatic test_border();
        logic [8:0] e_edge, e_top;
        set_win(316, 323, 236, 243);
        frame(0);
`ifdef CWR_BORDER_EN
        e_edge = BRD;
        e_top  = BRD;
`else
        e_edge = glyph(4, 0);
        e_top  = glyph(0, 2);
`endif
        for (int y = 236; y <= 240; y++) begin
            line(y, 0, 315, 324);
            if (y == 236) begin
                n_tests++;
                if (q_rgb[tag_x[318]+2] !== e_top) begin n_fail++; $display("FAIL border_top got %h exp %h", q_rgb[tag_x[318]+2], e_top); end
            end else if (y == 240) begin
                n_tests += 2;
                if (q_rgb[tag_x[316]+2] !== e_edge) begin n_fail++; $display("FAIL border_left got %h exp %h", q_rgb[tag_x[316]+2], e_edge); end
                if (q_rgb[tag_x[318]+2] !== glyph(4, 2)) begin n_fail++; $display("FAIL border_interior got %h exp %h", q_rgb[tag_x[318]+2], glyph(4, 2)); end
            end
        end
    endtask

    initial begin
        rom_mem[0] = 8'hA5; rom_mem[1] = 8'h3C; rom_mem[2] = 8'h81; rom_mem[3] = 8'hFF;
        rom_mem[4] = 8'h5A; rom_mem[5] = 8'h0F; rom_mem[6] = 8'hF0; rom_mem[7] = 8'h66;
        exp_a5[0] = FG; exp_a5[1] = BG; exp_a5[2] = FG; exp_a5[3] = BG;
        exp_a5[4] = BG; exp_a5[5] = FG; exp_a5[6] = BG; exp_a5[7] = FG;
        reset    = 1'b1;
        active   = 1'b0;
        pixelX   = 10'd0;
        pixelY   = 9'd0;
        charSize = 3'd0;
        set_win(316, 323, 236, 243);

        test_reset();
        test_s1_glyph();
        test_s2_scaling();
        test_mid_scale();
        test_hwrap();
        test_reset_mid();
        test_border();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/char_window_renderer.md
# char_window_renderer

Pixel-stage renderer directly downstream of the window-offset block. Consumes the character window bounds and the VGA timing generator's pixel coordinates. Issues glyph-ROM row reads, scales the 8×8 glyph by `charSize`, and drives the 9-bit (3-3-3) RGB pixel to the DAC. Handles windows that wrap around the right and bottom screen edges.

## Interface
- `FG_RGB`, 9'h1FF, glyph foreground colour
- `BG_RGB`, 9'h000, in-window background colour
- `BORDER_RGB`, 9'h1C0, border colour (used only with `CWR_BORDER_EN`)
- `clk`  in  1  pixel clock, one pixel per cycle
- `reset`  in  1  reset, asynchronous, active-high
- `active`  in  1  pixel is in the visible area
- `pixelX`  in  10  column, 0..639
- `pixelY`  in  9  row, 0..479
- `charSize`  in  3  scale select; scale s = charSize+1 (1..8)
- `posHorStart`, `posHorEnd`  in  10  window columns, inclusive
- `posVerStart`, `posVerEnd`  in  9  window rows, inclusive
- `romData`  in  8  glyph row bits, valid the cycle after `readEn`; bit 7 is the leftmost column
- `readEn`  out  1  ROM read strobe
- `rowCnt`  out  3  glyph row address
- `colCnt`  out  3  glyph column index
- `vgaRGB`  out  9  pixel colour

## Operation
- **Reset values.** All outputs are 0. All counters are 0. Latched scale is s=1.
- **Scale latch.** `charSize` is latched only on the cycle with `active && pixelX==0 && pixelY==0`. Mid-frame changes are ignored.
- **Horizontal window test.** Let hIn = (start ≤ end) ? (start ≤ x ≤ end) : (x ≥ start || x ≤ end).
- **Vertical window test.** vIn uses the same rule on y.
- **Horizontal counters.** Sub-pixel counter hSub runs 0..s-1; colCnt runs 0..7.
  - They advance only on `active && hIn`, independent of vIn.
  - At x==posHorStart both load 0.
  - hSub wraps at s-1 and increments colCnt; colCnt wraps 7→0.
  - Counters hold across horizontal blanking. A wrapped window's left segment (x ≤ end) therefore continues the column sequence from the previous line's right segment.
- **Vertical counters.** Sub-row counter vSub runs 0..s-1; rowCnt runs 0..7.
  - They advance on the last active pixel of a line (x==639, `active`) when vIn holds for that line.
  - They load 0 on the first active pixel of line y==posVerStart.
  - They hold across vertical blanking, so bottom-edge wrap works the same way as right-edge wrap.
- **Pipeline.** A pixel presented at cycle n produces:
  - `readEn`, `rowCnt`, `colCnt` at cycle n+1, with `readEn` = active && hIn && vIn.
  - `romData` at cycle n+2.
  - `vgaRGB` at cycle n+2.
- **Colour selection.**
  - Inside the window: `vgaRGB` = romData[7-colCnt_d] ? FG_RGB : BG_RGB.
  - Outside the window or not active: `vgaRGB` = 0.
- **First line after reset.** In the wrapped left segment, counters start from their reset value (0). Columns are correct from the second line onward.
- **Bounds changes.** Bounds may change at any time and take effect on the next compare. If a counter has not yet seen a start edge after the change, it continues from its current value.
- **Reset mid-frame.** Outputs go to 0 immediately. After reset release, rendering resumes with s=1.

## Timing
- Fixed latency: 2 cycles from `pixelX/pixelY` to `vgaRGB`, 1 cycle to `readEn`. No stalls, no handshake.
- The ROM is synchronous with 1-cycle read latency. `romData` is sampled unconditionally; it is ignored when the delayed window flag is 0.
- All state is registered on `posedge clk` or `posedge reset`. Window compares are combinational in stage 0.

## Configuration
- **`CWR_BORDER_EN` defined.** Pixels with x∈{start,end} and vIn, or y∈{start,end} and hIn, output BORDER_RGB. The border overrides glyph colour. The border flag is delayed with the same 2-cycle latency.
- **`CWR_BORDER_EN` undefined.** No border logic is built; window pixels show the glyph only.

## Structure
- **Package `vga_pkg`:**
  - Screen constants HDR=640, VDR=480.
  - Glyph constants GLYPH_W=8, GLYPH_H=8.
  - RGB_W=9.
  - Scale width 3.
- **Sub-module `scale_counter`.** Parameterised index width. Signals: sub-count to s-1, index wrap, load-zero, advance enable. Instantiated once for horizontal and once for vertical.

## Test plan
- **Reset.** Assert `reset` mid-line. Required: `vgaRGB`=0, `readEn`=0, `rowCnt`=0, `colCnt`=0 in the same cycle; rendering restarts with s=1 after release.
- **s=1 glyph.** Window 316..323 / 236..243, charSize=0, romData=8'hA5. Required: at y=236, x=316..323 give `vgaRGB` FG,BG,FG,BG,BG,FG,BG,FG at cycles n+2; `rowCnt` steps 0..7 over y=236..243.
- **s=2 scaling.** charSize=1 latched at frame start, window 312..327. Required: `colCnt` holds each value for 2 pixels, 0,0,1,1,…,7,7; `rowCnt` changes every second line.
- **Mid-frame scale change.** charSize changed at y=100. Required: no effect until the next x=0,y=0 pixel.
- **Horizontal wrap.** Window 636..3 (s=1). Required: on the second line, x=636..639 give colCnt 0..3 and x=0..3 give colCnt 4..7; x=4 outputs 0.
- **Border (`CWR_BORDER_EN`).** Window 316..323 / 236..243. Required: x=316 at y=240 outputs 9'h1C0 regardless of romData; an interior pixel follows the glyph.
